// File: rtl/pd_pkg.sv
// ---------------------------------------------------------------------------
// pd_pkg
// Shared definitions for the fetch stage: reset PC default, the NOP word
// loaded into the decode-facing instruction register on reset, the fetch FSM
// state encoding and a word-alignment helper.
// ---------------------------------------------------------------------------
package pd_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    HOLD   = 2'b01,
    BUBBLE = 2'b10
  } fetch_state_e;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// ---------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for a fetched instruction (pc + inst) that
// arrived while the decode-facing output register was stalled.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   flush        : discard the entry (highest priority)
//   load         : capture load_pc/load_inst, entry becomes valid
//   drain        : entry has been moved out, becomes empty
//   load_pc      : address of the instruction being captured
//   load_inst    : instruction word being captured
//   valid        : entry holds a live instruction
//   pc, inst     : held instruction address and word
// Load beats drain so a same-cycle drain and refill keeps the entry valid.
// ---------------------------------------------------------------------------
module fetch_skid_buffer
  import pd_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic        drain,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  logic        valid_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;

  // Holding register: flush, then load, then drain, otherwise keep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      pc_r    <= 32'h0000_0000;
      inst_r  <= NOP_INST;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      pc_r    <= load_pc;
      inst_r  <= load_inst;
    end else if (drain) begin
      valid_r <= 1'b0;
    end
  end

  assign valid = valid_r;
  assign pc    = pc_r;
  assign inst  = inst_r;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: PC register, one-cycle-latency instruction memory
// interface, registered output to decode plus one skid entry, and
// redirect handling from execute.
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   imem_req      : fetch request strobe
//   imem_addr     : word-aligned fetch address (always the PC register)
//   imem_data     : instruction returned one cycle after imem_req
//   stall_d       : decode cannot accept; output register holds
//   redirect      : taken branch/jump, redirect_pc is the new target
//   f_valid_d     : f_pc_d / f_inst_d hold a live instruction
//   f_pc_d        : instruction address to decode
//   f_inst_d      : instruction word to decode
// ---------------------------------------------------------------------------
module fetch_stage
  import pd_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        f_valid_d,
  output logic [31:0] f_pc_d,
  output logic [31:0] f_inst_d
);

  fetch_state_e state_r;
  fetch_state_e state_next_s;

  logic [31:0] pc_r;
  logic        inflight_r;
  logic [31:0] inflight_pc_r;
  logic        out_valid_r;
  logic [31:0] out_pc_r;
  logic [31:0] out_inst_r;

  logic        skid_valid_s;
  logic [31:0] skid_pc_s;
  logic [31:0] skid_inst_s;

  logic        load_out_s;
  logic        skid_load_s;
  logic        skid_drain_s;
  logic        skid_fill_s;
  logic        issue_s;

  // Buffer control. An empty output always loads, so stall only matters
  // when the output holds a live instruction. A request is withheld in the
  // cycle the skid fills: its response could not be stored anywhere.
  always_comb begin
    load_out_s   = 1'b0;
    skid_load_s  = 1'b0;
    skid_drain_s = 1'b0;
    skid_fill_s  = 1'b0;
    issue_s      = 1'b0;
    load_out_s   = ~out_valid_r | ~stall_d;
    skid_load_s  = inflight_r & (~load_out_s | skid_valid_s);
    skid_drain_s = skid_valid_s & load_out_s;
    skid_fill_s  = skid_load_s & ~skid_valid_s;
    issue_s      = (state_r == FETCH) & ~skid_fill_s;
  end

  // Requests are suppressed while reset is held; the address is the PC
  // register alone, so neither stall_d nor redirect reaches imem_addr.
  assign imem_req  = issue_s & ~reset;
  assign imem_addr = pc_r;

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; redirect wins from every state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH: begin
        if (redirect) begin
          state_next_s = BUBBLE;
        end else if (skid_fill_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_next_s = BUBBLE;
        end else if (skid_drain_s) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = HOLD;
        end
      end
      BUBBLE: begin
        if (redirect) begin
          state_next_s = BUBBLE;
        end else begin
          state_next_s = FETCH;
        end
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  // PC, in-flight tracking and decode-facing output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
      out_valid_r   <= 1'b0;
      out_pc_r      <= 32'h0000_0000;
      out_inst_r    <= NOP_INST;
    end else if (redirect) begin
      // The response to this cycle's request is killed with the output.
      pc_r        <= word_align(redirect_pc);
      inflight_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (issue_s) begin
        pc_r          <= pc_r + PC_STEP;
        inflight_pc_r <= pc_r;
      end
      inflight_r <= issue_s;
      if (load_out_s) begin
        if (skid_valid_s) begin
          out_valid_r <= 1'b1;
          out_pc_r    <= skid_pc_s;
          out_inst_r  <= skid_inst_s;
        end else if (inflight_r) begin
          out_valid_r <= 1'b1;
          out_pc_r    <= inflight_pc_r;
          out_inst_r  <= imem_data;
        end else begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  fetch_skid_buffer u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .load      (skid_load_s),
    .drain     (skid_drain_s),
    .load_pc   (inflight_pc_r),
    .load_inst (imem_data),
    .valid     (skid_valid_s),
    .pc        (skid_pc_s),
    .inst      (skid_inst_s)
  );

  assign f_valid_d = out_valid_r;
  assign f_pc_d    = out_pc_r;
  assign f_inst_d  = out_inst_r;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Drives fetch_stage with directed and random stall/redirect traffic and a
// one-cycle instruction memory whose contents are a fixed function of the
// address. A monitor on the falling edge compares the DUT with a model of
// the delivered instruction stream, request address stream and latencies.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0100_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        f_valid_d;
  logic [31:0] f_pc_d;
  logic [31:0] f_inst_d;

  int checks   = 0;
  int failures = 0;

  fetch_stage dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall_d     (stall_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .f_valid_d   (f_valid_d),
    .f_pc_d      (f_pc_d),
    .f_inst_d    (f_inst_d)
  );

  always #5 clock = ~clock;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock cycle: apply inputs, sample the request mid-cycle, answer it
  // just after the rising edge.
  logic        cap_req;
  logic [31:0] cap_addr;
  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc);
    stall_d     = st;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clock);
    cap_req  = imem_req;
    cap_addr = imem_addr;
    @(posedge clock);
    #1;
    imem_data = cap_req ? memf(cap_addr) : $urandom;
  endtask

  // Reference model state.
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  bit          lat_on, lat_rst, hold_pend;
  int          lat_cnt, lat_tgt, stall_run, idle_run;

  // Monitor: compare every cycle, then advance the model across the edge.
  always @(negedge clock) begin
    if (reset) begin
      chkb("rst_valid", f_valid_d, 1'b0);
      chkb("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_pc", f_pc_d, 32'h0000_0000);
      chk("rst_inst", f_inst_d, NOP);
      exp_pc    = RST_PC;
      exp_req   = RST_PC;
      lat_on    = 1'b1;
      lat_rst   = 1'b1;
      lat_cnt   = -1;
      lat_tgt   = 2;
      hold_pend = 1'b0;
      stall_run = 0;
      idle_run  = 0;
    end else begin
      if (lat_on) begin
        lat_cnt++;
        if (lat_cnt < lat_tgt) begin
          chkb("lat_empty", f_valid_d, 1'b0);
        end else begin
          chkb("lat_valid", f_valid_d, 1'b1);
          lat_on = 1'b0;
        end
        if (lat_rst && lat_cnt == 0) chkb("first_req", imem_req, 1'b1);
        if (!lat_rst && lat_cnt == 1) chkb("bubble_req", imem_req, 1'b0);
        if (!lat_rst && lat_cnt == 2) chkb("target_req", imem_req, 1'b1);
      end
      if (hold_pend) chkb("stall_hold", f_valid_d, 1'b1);
      if (f_valid_d) begin
        chk("f_pc_d", f_pc_d, exp_pc);
        chk("f_inst_d", f_inst_d, memf(exp_pc));
      end
      if (imem_req) begin
        chk("imem_addr", imem_addr, exp_req);
        exp_req = exp_req + 32'h0000_0004;
      end
      if (f_valid_d && stall_d && stall_run >= 2) chkb("req_drop", imem_req, 1'b0);
      idle_run = f_valid_d ? 0 : idle_run + 1;
      if (!f_valid_d) chkb("liveness", (idle_run <= 4), 1'b1);
      if (redirect) begin
        exp_pc    = redirect_pc & 32'hFFFF_FFFC;
        exp_req   = redirect_pc & 32'hFFFF_FFFC;
        lat_on    = 1'b1;
        lat_rst   = 1'b0;
        lat_cnt   = 0;
        lat_tgt   = 4;
        hold_pend = 1'b0;
        stall_run = 0;
        idle_run  = 0;
      end else begin
        hold_pend = f_valid_d && stall_d;
        stall_run = (f_valid_d && stall_d) ? stall_run + 1 : 0;
        if (f_valid_d && !stall_d) exp_pc = exp_pc + 32'h0000_0004;
      end
    end
  end

  logic [31:0] frozen;

  initial begin
    reset       = 1'b1;
    stall_d     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    imem_data   = 32'h0000_0000;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset release: first instruction two cycles later, then +4 per cycle.
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chkb("pin_first_valid", f_valid_d, 1'b1);
    chk("pin_first_pc", f_pc_d, 32'h0100_0000);
    cyc(1'b0, 1'b0, 32'h0);
    chk("pin_second_pc", f_pc_d, 32'h0100_0004);
    cyc(1'b0, 1'b0, 32'h0);
    chk("pin_third_pc", f_pc_d, 32'h0100_0008);

    // Light random stalls.
    for (int i = 0; i < 30; i++) cyc(($urandom_range(0, 3) == 0), 1'b0, 32'h0);

    // Five-cycle stall mid-stream.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0);
    frozen = f_pc_d;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("pin_stall_frozen", f_pc_d, frozen);
    end
    chkb("pin_stall_req_low", imem_req, 1'b0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("pin_stall_next", f_pc_d, frozen + 32'h0000_0004);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 32'h0);

    // Redirect while streaming.
    cyc(1'b0, 1'b1, 32'h0100_0100);
    chkb("pin_redir_kill", f_valid_d, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
    chkb("pin_redir_valid", f_valid_d, 1'b1);
    chk("pin_redir_pc", f_pc_d, 32'h0100_0100);

    // Redirect with stall and a full skid; low target bits are ignored.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0100_0203);
    chkb("pin_flush_kill", f_valid_d, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0);
    chkb("pin_flush_valid", f_valid_d, 1'b1);
    chk("pin_flush_pc", f_pc_d, 32'h0100_0200);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0);

    // Address wrap at the top of the address space.
    cyc(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
    chk("pin_wrap_a", f_pc_d, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b0, 32'h0);
    chk("pin_wrap_b", f_pc_d, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0);
    chkb("pin_wrap_valid", f_valid_d, 1'b1);
    chk("pin_wrap_c", f_pc_d, 32'h0000_0000);

    // Random stalls and redirects.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), $urandom);
    end

    // Asynchronous reset while holding with the skid full.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chkb("pin_async_valid", f_valid_d, 1'b0);
    chk("pin_async_pc", f_pc_d, 32'h0000_0000);
    chk("pin_async_inst", f_inst_d, NOP);
    chkb("pin_async_req", imem_req, 1'b0);
    chk("pin_async_addr", imem_addr, RST_PC);
    @(posedge clock);
    #1;
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chkb("pin_restart_valid", f_valid_d, 1'b1);
    chk("pin_restart_pc", f_pc_d, 32'h0100_0000);

    // Closing random traffic.
    for (int i = 0; i < 100; i++) begin
      cyc(($urandom_range(0, 9) < 4), ($urandom_range(0, 29) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0100_0000, meaning the first instruction address after reset.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port imem_req, output, 1, fetch request strobe to instruction memory.
REQ-005 SHALL have port imem_addr, output, 32, word-aligned fetch address, valid when imem_req=1.
REQ-006 SHALL have port imem_data, input, 32, instruction returned exactly one cycle after the request.
REQ-007 SHALL have port stall_d, input, 1, decode cannot accept; output register must hold.
REQ-008 SHALL have port redirect, input, 1, taken branch/jump from execute.
REQ-009 SHALL have port redirect_pc, input, 32, target address, sampled when redirect=1.
REQ-010 SHALL have port f_valid_d, output, 1, f_pc_d/f_inst_d hold a live instruction.
REQ-011 SHALL have ports f_pc_d (output, 32, instruction address) and f_inst_d (output, 32, instruction word) feeding decode.

Function
REQ-012 SHALL keep a PC register, issuing request at PC and advancing PC by 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) on every issued request.
REQ-013 SHALL hold instructions in a registered output stage plus one skid entry; maximum two instructions buffered.
REQ-014 SHALL implement FSM states FETCH, HOLD, BUBBLE; reset state FETCH.
REQ-015 FETCH: imem_req=1; to HOLD when skid becomes full this cycle; to BUBBLE on redirect.
REQ-016 HOLD: imem_req=0, PC unchanged; to FETCH in the cycle the skid drains into the output register; to BUBBLE on redirect.
REQ-017 BUBBLE: imem_req=0 for exactly one cycle after a redirect; to FETCH unconditionally (or stay BUBBLE on repeated redirect).
REQ-018 Output register SHALL load when f_valid_d=0 or stall_d=0: from skid if skid valid, else from the in-flight response, else f_valid_d<=0.
REQ-019 In-flight response arriving while output holds (stall_d=1, f_valid_d=1) SHALL be written to the skid; no response is ever dropped except by redirect.
REQ-020 Redirect SHALL have priority over stall: same edge clears f_valid_d and skid, kills the in-flight response, loads PC<=redirect_pc.
REQ-021 Redirect latency: redirect at cycle t -> request for redirect_pc at t+2 -> f_valid_d=1, f_pc_d=redirect_pc at t+4.
REQ-022 Steady state with stall_d=0 SHALL deliver one instruction per cycle, f_pc_d increasing by 4.
REQ-023 stall_d SHALL be ignored while f_valid_d=0 (empty output always loads).
REQ-024 redirect_pc[1:0] SHALL be forced to 2'b00.

Reset
REQ-025 Asserting reset SHALL asynchronously set PC=RESET_PC, state=FETCH, f_valid_d=0, f_pc_d=0, f_inst_d=32'h0000_0013 (NOP), skid empty, in-flight killed.
REQ-026 During reset imem_req=0, imem_addr=RESET_PC; first request in the first cycle after release; reset mid-stall/mid-redirect discards everything.

Structure
REQ-027 SHALL place RESET_PC default, NOP_INST constant and FSM state encoding in shared package pd_pkg.
REQ-028 SHALL instantiate one sub-module fetch_skid_buffer (1-entry pc+inst holding register with valid, load, drain, flush).
REQ-029 SHALL contain no combinational path from stall_d or redirect to imem_addr.

Verification
REQ-030 Reset release, stall_d=0 -> f_valid_d rises 2 cycles later with f_pc_d=32'h0100_0000, then 0x..04, 0x..08 each cycle.
REQ-031 stall_d=1 for 5 cycles mid-stream -> f_pc_d frozen, imem_req drops after skid fills, release yields consecutive PCs with no gap or duplicate.
REQ-032 redirect=1, redirect_pc=32'h0100_0100 -> f_valid_d=0 next cycle, f_pc_d=32'h0100_0100 valid 4 cycles after redirect, killed instruction never appears.
REQ-033 redirect and stall_d both 1 with skid full -> skid and output flushed, target fetched as in REQ-032.
REQ-034 PC at 32'hFFFF_FFFC, no stall -> next f_pc_d=32'h0000_0000.
REQ-035 reset asserted while HOLD with skid full -> outputs at reset values immediately (asynchronously), restart from RESET_PC.
